// File: rtl/pxconv_rd_sched.sv
// Read scheduler for the pixel-converter AXI burst master: primes a WND_ROWS-row window,
// then fetches one further row per consumer credit. Define PXSCHED_PERF_EN to add stall_cycles.
module pxconv_rd_sched #(
   parameter logic [31:0] FRAME_BASE   = 32'h0000_0000,
   parameter int          IMG_W        = 640,
   parameter int          IMG_H        = 480,
   parameter int          WND_ROWS     = 8,
   parameter int          BURST_LEN    = 128,
   parameter int          BYTES_PER_PX = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        pixel_ack,
   input  logic        rd_done,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   output logic [11:0] rd_len,
   output logic        wnd_ready,
   output logic [15:0] row_cnt,
   output logic        frame_done,
   output logic        busy
`ifdef PXSCHED_PERF_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam logic [31:0] ADDR_STEP  = 32'(BURST_LEN * BYTES_PER_PX);
   localparam logic [15:0] BURST_LAST = 16'(IMG_W / BURST_LEN - 1);
   localparam logic [15:0] ROWS_TOTAL = 16'(IMG_H);
   localparam logic [15:0] ROWS_WND   = 16'(WND_ROWS);
   localparam logic [11:0] LEN_PX     = 12'(BURST_LEN);

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_ISSUE       = 2'd1,
      ST_WAIT_DONE   = 2'd2,
      ST_WAIT_CREDIT = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [15:0] burst_idx_r;
   logic [7:0]  credit_r;
   logic [15:0] row_next_s;
   logic        start_s;
   logic        burst_done_s;
   logic        row_end_s;
   logic        frame_end_s;
   logic        credit_take_s;
   logic        credit_give_s;

   // Event decode shared by the FSM and the datapath registers
   always_comb begin
      start_s       = (state_r == ST_IDLE) && frame_start && !frame_done;
      burst_done_s  = (state_r == ST_WAIT_DONE) && rd_done;
      row_next_s    = row_cnt + 16'd1;
      row_end_s     = burst_done_s && (burst_idx_r == BURST_LAST);
      frame_end_s   = row_end_s && (row_next_s == ROWS_TOTAL);
      credit_take_s = (state_r == ST_WAIT_CREDIT) && (credit_r != 8'd0);
      credit_give_s = pixel_ack && (state_r != ST_IDLE);
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_s = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!burst_done_s) begin
               state_s = ST_WAIT_DONE;
            end else if (!row_end_s) begin
               state_s = ST_ISSUE;
            end else if (frame_end_s) begin
               state_s = ST_IDLE;
            end else if (row_next_s < ROWS_WND) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_WAIT_CREDIT;
            end
         end
         ST_WAIT_CREDIT: begin
            if (credit_take_s) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_WAIT_CREDIT;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered control pulses; busy tracks the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rd_req     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_r    <= state_s;
         rd_req     <= (state_r == ST_ISSUE);
         busy       <= (state_s != ST_IDLE);
         frame_done <= frame_end_s;
      end
   end

   // Address, burst/row position and window flag; only move on an accepted rd_done
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr     <= 32'h0000_0000;
         rd_len      <= LEN_PX;
         row_cnt     <= 16'd0;
         burst_idx_r <= 16'd0;
         wnd_ready   <= 1'b0;
      end else begin
         rd_len <= LEN_PX;
         if (start_s) begin
            rd_addr     <= FRAME_BASE;
            row_cnt     <= 16'd0;
            burst_idx_r <= 16'd0;
         end else if (burst_done_s) begin
            rd_addr <= rd_addr + ADDR_STEP;
            if (row_end_s) begin
               burst_idx_r <= 16'd0;
               row_cnt     <= row_next_s;
            end else begin
               burst_idx_r <= burst_idx_r + 16'd1;
            end
         end
         if (frame_end_s) begin
            wnd_ready <= 1'b0;
         end else if (row_end_s && (row_next_s == ROWS_WND)) begin
            wnd_ready <= 1'b1;
         end
      end
   end

   // Row credits: saturating, a simultaneous grant and use cancel out
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_r <= 8'd0;
      end else if (start_s) begin
         credit_r <= 8'd0;
      end else begin
         case ({credit_give_s, credit_take_s})
            2'b10: begin
               if (credit_r != 8'hFF) begin
                  credit_r <= credit_r + 8'd1;
               end
            end
            2'b01: begin
               credit_r <= credit_r - 8'd1;
            end
            default: begin
               credit_r <= credit_r;
            end
         endcase
      end
   end

`ifdef PXSCHED_PERF_EN
   // Cycles spent starved of credit, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'h0000_0000;
      end else if (start_s) begin
         stall_cycles <= 32'h0000_0000;
      end else if ((state_r == ST_WAIT_CREDIT) && (credit_r == 8'd0) &&
                   (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pxconv_rd_sched.sv
// Randomised bench for pxconv_rd_sched: an event-level model predicts every output each cycle,
// and literal expectations pin the window, credit, full-frame and reset scenarios.
module tb_pxconv_rd_sched;

   localparam int ROWS = 480;
   localparam int WND  = 8;
   localparam int BPR  = 5;

   logic        clk;
   logic        rst;
   logic        frame_start;
   logic        pixel_ack;
   logic        rd_done;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [11:0] rd_len;
   logic        wnd_ready;
   logic [15:0] row_cnt;
   logic        frame_done;
   logic        busy;
`ifdef PXSCHED_PERF_EN
   logic [31:0] stall_cycles;
`endif

   pxconv_rd_sched dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pixel_ack   (pixel_ack),
      .rd_done     (rd_done),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_len      (rd_len),
      .wnd_ready   (wnd_ready),
      .row_cnt     (row_cnt),
      .frame_done  (frame_done),
      .busy        (busy)
`ifdef PXSCHED_PERF_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   int vectors;
   int miscompares;
   int cyc;

   // model: expected outputs for the current cycle plus frame bookkeeping
   bit          e_req;
   bit          e_wnd;
   bit          e_done;
   bit          e_busy;
   logic [31:0] e_addr;
   logic [31:0] e_stall;
   int          e_row;
   int          m_bursts;
   int          m_credit;
   bit          m_out;
   bit          m_wait;
   int          req_at;

   int          req_cnt;
   int          done_cnt;
   logic [31:0] last_req_addr;

   int unsigned lat_min;
   int unsigned lat_max;
   int          pend;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // AXI read slave: rd_done a random number of cycles after each rd_req
   initial begin
      rd_done = 1'b0;
      pend    = 0;
      forever begin
         @(posedge clk);
         #1;
         rd_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) rd_done = 1'b1;
         end
         if (rd_req === 1'b1) pend = int'($urandom_range(lat_max, lat_min));
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic m_reset();
      e_req    = 1'b0;
      e_wnd    = 1'b0;
      e_done   = 1'b0;
      e_busy   = 1'b0;
      e_addr   = 32'd0;
      e_stall  = 32'd0;
      e_row    = 0;
      m_bursts = 0;
      m_credit = 0;
      m_out    = 1'b0;
      m_wait   = 1'b0;
      req_at   = -1;
   endtask

   // compare the current cycle, then advance the model with this cycle's inputs
   task automatic step();
      bit cur_busy;
      bit cur_done;
      bit inc;
      bit dec;
      cyc++;
      cmp("rd_req", 32'(rd_req), 32'(e_req));
      cmp("rd_addr", rd_addr, e_addr);
      cmp("rd_len", 32'(rd_len), 32'd128);
      cmp("wnd_ready", 32'(wnd_ready), 32'(e_wnd));
      cmp("row_cnt", 32'(row_cnt), 32'(e_row));
      cmp("frame_done", 32'(frame_done), 32'(e_done));
      cmp("busy", 32'(busy), 32'(e_busy));
`ifdef PXSCHED_PERF_EN
      cmp("stall_cycles", stall_cycles, e_stall);
`endif
      if (rd_req === 1'b1) begin
         req_cnt++;
         last_req_addr = rd_addr;
      end
      if (frame_done === 1'b1) done_cnt++;

      cur_busy = e_busy;
      cur_done = e_done;
      if (rst) begin
         m_reset();
      end else begin
         if (e_req) m_out = 1'b1;
         e_done = 1'b0;
         dec    = 1'b0;
         if (!cur_busy && frame_start && !cur_done) begin
            e_busy   = 1'b1;
            e_addr   = 32'd0;
            e_row    = 0;
            m_bursts = 0;
            m_credit = 0;
            e_stall  = 32'd0;
            m_wait   = 1'b0;
            req_at   = cyc + 2;
            req_cnt  = 0;
         end
         inc = pixel_ack && cur_busy;
         if (m_wait) begin
            if (m_credit > 0) begin
               dec    = 1'b1;
               m_wait = 1'b0;
               req_at = cyc + 2;
            end else if (e_stall != 32'hFFFF_FFFF) begin
               e_stall = e_stall + 32'd1;
            end
         end
         if (rd_done && m_out) begin
            m_out = 1'b0;
            m_bursts++;
            e_addr = e_addr + 32'd256;
            if (m_bursts % BPR == 0) begin
               e_row = m_bursts / BPR;
               if (e_row == ROWS) begin
                  e_done = 1'b1;
                  e_busy = 1'b0;
                  e_wnd  = 1'b0;
               end else begin
                  if (e_row == WND) e_wnd = 1'b1;
                  if (e_row < WND) req_at = cyc + 2;
                  else m_wait = 1'b1;
               end
            end else begin
               req_at = cyc + 2;
            end
         end
         if (inc && !dec) m_credit = (m_credit < 255) ? m_credit + 1 : 255;
         else if (dec && !inc) m_credit--;
         e_req = (req_at == cyc + 1);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wnd(input int budget);
      int n = 0;
      while (wnd_ready !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      cmp("wait_wnd_ready", 32'(wnd_ready), 32'd1);
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (rd_req !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      cmp("wait_rd_req", 32'(rd_req), 32'd1);
   endtask

   // pulse pixel_ack in the same cycle as the count-th rd_done from now
   task automatic ack_with_done(input int count, input int budget);
      int seen = 0;
      int n    = 0;
      while (seen < count && n < budget) begin
         #1;
         if (rd_done === 1'b1) begin
            seen++;
            if (seen == count) pixel_ack = 1'b1;
         end
         tick();
         pixel_ack = 1'b0;
         n++;
      end
      cmp("ack_with_done", 32'(seen), 32'(count));
   endtask

   initial begin
      int n;
      int k;
      vectors       = 0;
      miscompares   = 0;
      cyc           = 0;
      rst           = 1'b1;
      frame_start   = 1'b0;
      pixel_ack     = 1'b0;
      lat_min       = 5;
      lat_max       = 5;
      req_cnt       = 0;
      done_cnt      = 0;
      last_req_addr = 32'd0;
      m_reset();
      @(posedge clk);
      #1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      cmp("lit_reset_len", 32'(rd_len), 32'd128);
      cmp("lit_reset_addr", rd_addr, 32'd0);

      // prime the window, then hold off credit for 100 stalled cycles
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      wait_wnd(2000);
      repeat (99) tick();
      cmp("lit_prime_reqs", 32'(req_cnt), 32'd40);
      cmp("lit_prime_last", last_req_addr, 32'h0000_2700);
      cmp("lit_prime_addr", rd_addr, 32'h0000_2800);
      cmp("lit_prime_rows", 32'(row_cnt), 32'd8);
      pixel_ack = 1'b1;
      tick();
      pixel_ack = 1'b0;
`ifdef PXSCHED_PERF_EN
      cmp("lit_stall_100", stall_cycles, 32'd100);
`endif
      repeat (60) tick();
      cmp("lit_credit1_reqs", 32'(req_cnt), 32'd45);
      cmp("lit_credit1_last", last_req_addr, 32'h0000_2C00);
      cmp("lit_credit1_rows", 32'(row_cnt), 32'd9);

      pixel_ack = 1'b1;
      repeat (3) tick();
      pixel_ack = 1'b0;
      repeat (150) tick();
      cmp("lit_credit3_reqs", 32'(req_cnt), 32'd60);
      cmp("lit_credit3_rows", 32'(row_cnt), 32'd12);

      // ack coinciding with the row-ending rd_done still grants the next row
      pixel_ack = 1'b1;
      tick();
      pixel_ack = 1'b0;
      ack_with_done(5, 200);
      repeat (60) tick();
      cmp("lit_simul_rows", 32'(row_cnt), 32'd14);
      cmp("lit_simul_reqs", 32'(req_cnt), 32'd70);

      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      cmp("lit_midframe_busy", 32'(busy), 32'd1);

      // rest of the frame with random latency and ack pacing
      lat_min = 1;
      lat_max = 4;
      n = 0;
      while (frame_done !== 1'b1 && n < 40000) begin
         pixel_ack = ($urandom_range(32'd23, 32'd0) == 32'd0);
         tick();
         n++;
      end
      pixel_ack = 1'b0;
      cmp("frame_done_seen", 32'(frame_done), 32'd1);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      cmp("lit_frame_reqs", 32'(req_cnt), 32'd2400);
      cmp("lit_frame_last", last_req_addr, 32'h0009_5F00);
      cmp("lit_frame_rows", 32'(row_cnt), 32'd480);
      cmp("lit_frame_idle", 32'(busy), 32'd0);
      cmp("lit_frame_pulses", 32'(done_cnt), 32'd1);

      // acks in IDLE must not carry into the next frame
      repeat (3) begin
         pixel_ack = 1'b1;
         tick();
         pixel_ack = 1'b0;
         tick();
      end
      lat_min = 5;
      lat_max = 5;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
`ifdef PXSCHED_PERF_EN
      cmp("lit_stall_cleared", stall_cycles, 32'd0);
`endif
      wait_wnd(2000);
      repeat (50) tick();
      cmp("lit_frame2_reqs", 32'(req_cnt), 32'd40);
      cmp("lit_frame2_rows", 32'(row_cnt), 32'd8);

      // reset between rd_req and rd_done
      pixel_ack = 1'b1;
      tick();
      pixel_ack = 1'b0;
      wait_req(50);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cmp("lit_rst_addr", rd_addr, 32'd0);
      cmp("lit_rst_rows", 32'(row_cnt), 32'd0);
      cmp("lit_rst_busy", 32'(busy), 32'd0);
      cmp("lit_rst_wnd", 32'(wnd_ready), 32'd0);
      k = req_cnt;
      repeat (12) tick();
      cmp("lit_rst_no_req", 32'(req_cnt), 32'(k));
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      wait_req(10);
      cmp("lit_restart_addr", rd_addr, 32'd0);
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
